phase_sequencer: RTL and testbench

- Derives the per-machine-cycle phase strobes (ctrl, read, write, release) that sequence the control unit and bus agents.
- Runs from a single system clock.
- Provides run, single-step and halt control, including the control unit's stop-clock micro-op.
- Counts completed machine cycles for debug.

---
 rtl/phase_sequencer.sv | 120 ++++++++++++
 tb/tb_phase_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Machine-cycle phase sequencer: one-hot registered strobes CTRL/READ/WRITE/RELEASE, 4 clk per cycle,
// first CTRL 1 clk after the start condition; run/step/halt control, no backpressure (halt is the only stall).
module phase_sequencer #(
    parameter int RESET_HOLD  = 4,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run_req,
    input  logic                   step_req,
    input  logic                   halt_req,
    output logic                   ctrl_phase,
    output logic                   read_phase,
    output logic                   write_phase,
    output logic                   release_phase,
    output logic                   running,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    localparam int HW = $clog2(RESET_HOLD + 1);

    typedef enum logic [2:0] {
        S_HOLD, S_IDLE, S_CTRL, S_READ, S_WRITE, S_RELEASE, S_HALTED
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [HW-1:0]   r_hold;
    logic            r_step;
    logic            r_halt;
    logic            r_run_d;
    logic            w_step_nxt;
    logic            w_halt_nxt;
    logic            w_run_rise;

    assign w_run_rise = run_req & ~r_run_d;

    always_comb begin
        w_next     = r_state;
        w_step_nxt = r_step;
        w_halt_nxt = r_halt;
        case (r_state)
            S_HOLD: begin
                if (r_hold <= HW'(1)) w_next = S_IDLE;
            end
            S_IDLE: begin
                if (run_req) begin
                    w_next = S_CTRL;
                end else if (step_req) begin
                    w_next     = S_CTRL;
                    w_step_nxt = 1'b1;
                end
            end
            S_CTRL:  w_next = S_READ;
            S_READ: begin
                w_next = S_WRITE;
                if (halt_req) w_halt_nxt = 1'b1;
            end
            S_WRITE: w_next = S_RELEASE;
            S_RELEASE: begin
                // A halt latched in READ outranks a pending single step.
                if (r_halt) begin
                    w_next     = S_HALTED;
                    w_halt_nxt = 1'b0;
                    w_step_nxt = 1'b0;
                end else if (r_step) begin
                    w_next     = S_IDLE;
                    w_step_nxt = 1'b0;
                end else if (run_req) begin
                    w_next = S_CTRL;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_HALTED: begin
                if (step_req) begin
                    w_next     = S_CTRL;
                    w_step_nxt = 1'b1;
                end else if (w_run_rise) begin
                    w_next = S_CTRL;
                end
            end
            default: w_next = S_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_HOLD;
            r_hold        <= HW'(RESET_HOLD);
            r_step        <= 1'b0;
            r_halt        <= 1'b0;
            r_run_d       <= 1'b0;
            cycle_count   <= '0;
            ctrl_phase    <= 1'b0;
            read_phase    <= 1'b0;
            write_phase   <= 1'b0;
            release_phase <= 1'b0;
            running       <= 1'b0;
            halted        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_step  <= w_step_nxt;
            r_halt  <= w_halt_nxt;
            r_run_d <= run_req;
            if (r_state == S_HOLD && r_hold != '0) r_hold <= r_hold - HW'(1);
            if (r_state == S_RELEASE) cycle_count <= cycle_count + COUNT_WIDTH'(1);
            // Outputs decode the next state so each strobe coincides with its state.
            ctrl_phase    <= (w_next == S_CTRL);
            read_phase    <= (w_next == S_READ);
            write_phase   <= (w_next == S_WRITE);
            release_phase <= (w_next == S_RELEASE);
            running       <= (w_next == S_CTRL) || (w_next == S_READ) ||
                             (w_next == S_WRITE) || (w_next == S_RELEASE);
            halted        <= (w_next == S_HALTED);
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed vector bench for phase_sequencer; a second instance with a 4-bit counter shares the stimulus.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run_req, step_req, halt_req;
    logic        ctrl_phase, read_phase, write_phase, release_phase, running, halted;
    logic [31:0] cycle_count;
    logic        c4, r4, w4, l4, run4, h4;
    logic [3:0]  cycle_count4;

    int n_vec  = 0;
    int n_fail = 0;

    localparam logic [5:0] ZZ = 6'b000000;
    localparam logic [5:0] CC = 6'b100010;
    localparam logic [5:0] RR = 6'b010010;
    localparam logic [5:0] WW = 6'b001010;
    localparam logic [5:0] LL = 6'b000110;
    localparam logic [5:0] HH = 6'b000001;

    typedef struct {
        logic        run;
        logic        step;
        logic        halt;
        logic [5:0]  exp;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];

    phase_sequencer #(.RESET_HOLD(4), .COUNT_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
        .ctrl_phase(ctrl_phase), .read_phase(read_phase), .write_phase(write_phase),
        .release_phase(release_phase), .running(running), .halted(halted), .cycle_count(cycle_count)
    );

    phase_sequencer #(.RESET_HOLD(4), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
        .ctrl_phase(c4), .read_phase(r4), .write_phase(w4),
        .release_phase(l4), .running(run4), .halted(h4), .cycle_count(cycle_count4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic run, input logic step, input logic halt,
                                input logic [5:0] e, input logic [31:0] c);
        vec_t v;
        v.run = run; v.step = step; v.halt = halt; v.exp = e; v.cnt = c;
        tbl.push_back(v);
    endfunction

    // hr: halt_req on the edge leaving READ; hx: halt_req on the other edges of the cycle.
    function automatic void add_cyc(input logic run, input logic step, input logic hr,
                                    input logic hx, input logic [31:0] c);
        add(run, step, hx, CC, c);
        add(run, 1'b0, hx, RR, c);
        add(run, 1'b0, hr, WW, c);
        add(run, 1'b0, hx, LL, c);
    endfunction

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            run_req  = tbl[i].run;
            step_req = tbl[i].step;
            halt_req = tbl[i].halt;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d] strobes", name, i),
                  32'({ctrl_phase, read_phase, write_phase, release_phase, running, halted}),
                  32'(tbl[i].exp));
            check($sformatf("%s[%0d] count", name, i), cycle_count, tbl[i].cnt);
            check($sformatf("%s[%0d] count4", name, i), 32'(cycle_count4), tbl[i].cnt & 32'hF);
        end
        tbl.delete();
        run_req  = 1'b0;
        step_req = 1'b0;
        halt_req = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        run_req  = 1'b1;
        step_req = 1'b0;
        halt_req = 1'b0;
        #12;
        check("reset strobes", 32'({ctrl_phase, read_phase, write_phase, release_phase, running, halted}), 32'(ZZ));
        check("reset count", cycle_count, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Free run from reset: 4 clk of HOLD, then back-to-back cycles; 4-bit copy wraps at 16.
        for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 1'b0, ZZ, 0);
        for (int k = 0; k < 17; k++) add_cyc(1'b1, 1'b0, 1'b0, 1'b0, k);
        add(1'b1, 1'b0, 1'b0, CC, 17);
        add(1'b1, 1'b0, 1'b0, RR, 17);
        add(1'b1, 1'b0, 1'b0, WW, 17);
        run_table("freerun");
        run_req = 1'b1;

        // Asynchronous reset in the middle of WRITE.
        #1;
        reset_n = 1'b0;
        #1;
        check("async write_phase", 32'(write_phase), 32'd0);
        check("async running", 32'(running), 32'd0);
        check("async count", cycle_count, 32'd0);
        check("async count4", 32'(cycle_count4), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // HOLD repeats (step ignored in HOLD), halt only honoured in READ of cycle 5.
        add(1'b1, 1'b0, 1'b0, ZZ, 0);
        add(1'b1, 1'b1, 1'b0, ZZ, 0);
        add(1'b1, 1'b0, 1'b0, ZZ, 0);
        add(1'b1, 1'b0, 1'b0, ZZ, 0);
        add_cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
        add_cyc(1'b1, 1'b0, 1'b0, 1'b1, 1);
        add_cyc(1'b1, 1'b0, 1'b0, 1'b0, 2);
        add_cyc(1'b1, 1'b0, 1'b0, 1'b0, 3);
        add_cyc(1'b1, 1'b0, 1'b1, 1'b0, 4);
        add(1'b1, 1'b0, 1'b0, HH, 5);
        add(1'b1, 1'b0, 1'b0, HH, 5);
        add(1'b1, 1'b0, 1'b0, HH, 5);
        add(1'b0, 1'b0, 1'b0, HH, 5);
        add_cyc(1'b1, 1'b0, 1'b0, 1'b0, 5);
        add(1'b0, 1'b0, 1'b0, ZZ, 6);
        run_table("halt");

        // Single step; a step during WRITE is dropped.
        add(1'b0, 1'b1, 1'b0, CC, 6);
        add(1'b0, 1'b0, 1'b0, RR, 6);
        add(1'b0, 1'b0, 1'b0, WW, 6);
        add(1'b0, 1'b1, 1'b0, LL, 6);
        add(1'b0, 1'b0, 1'b0, ZZ, 7);
        add(1'b0, 1'b0, 1'b0, ZZ, 7);
        // run+step together in IDLE: run wins, cycles stay back-to-back.
        add_cyc(1'b1, 1'b1, 1'b0, 1'b0, 7);
        add_cyc(1'b1, 1'b0, 1'b0, 1'b0, 8);
        add(1'b0, 1'b0, 1'b0, ZZ, 9);
        // halt during a step cycle ends in HALTED.
        add_cyc(1'b0, 1'b1, 1'b1, 1'b0, 9);
        add(1'b0, 1'b0, 1'b0, HH, 10);
        add(1'b0, 1'b0, 1'b0, HH, 10);
        // step out of HALTED with run low returns to IDLE.
        add_cyc(1'b0, 1'b1, 1'b0, 1'b0, 10);
        add(1'b0, 1'b0, 1'b0, ZZ, 11);
        add(1'b0, 1'b0, 1'b0, ZZ, 11);
        // step out of HALTED with run held high, then free run resumes.
        add_cyc(1'b1, 1'b0, 1'b1, 1'b0, 11);
        add(1'b1, 1'b0, 1'b0, HH, 12);
        add(1'b1, 1'b0, 1'b0, HH, 12);
        add_cyc(1'b1, 1'b1, 1'b0, 1'b0, 12);
        add(1'b1, 1'b0, 1'b0, ZZ, 13);
        add_cyc(1'b1, 1'b0, 1'b0, 1'b0, 13);
        add(1'b1, 1'b0, 1'b0, CC, 14);
        run_table("step");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
